// File: rtl/hex_prio_encoder_rr.sv
// Registered N-bit request encoder with LSB-first, MSB-first and round-robin
// selection, plus zero/multi-hot flags and a population count.
module hex_prio_encoder_rr #(
   parameter  int N = 16,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_none,
   output logic         out_multi,
   output logic [W:0]   out_count
);

   localparam logic [1:0] MODE_LSB = 2'd0;
   localparam logic [1:0] MODE_MSB = 2'd1;
   localparam logic [1:0] MODE_RR  = 2'd2;

   logic         valid_q, valid_d;
   logic [W-1:0] idx_q, idx_d;
   logic         none_q, none_d;
   logic         multi_q, multi_d;
   logic [W:0]   count_q, count_d;
   logic [W-1:0] rr_ptr_q, rr_ptr_d;

   logic         accept_s;
   logic [W-1:0] idx_lsb_s, idx_msb_s, idx_rr_s, idx_sel_s;
   logic [W:0]   count_s;
   logic         none_s;
   logic         multi_s;

   function automatic logic [W-1:0] find_lsb(input logic [N-1:0] v);
      logic [W-1:0] r;
      r = {W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         r = v[W'(i)] ? W'(i) : r;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] find_msb(input logic [N-1:0] v);
      logic [W-1:0] r;
      r = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         r = v[W'(i)] ? W'(i) : r;
      end
      return r;
   endfunction

   // Upward search starting at ptr, wrapping N-1 -> 0; works for non-power-of-two N.
   function automatic logic [W-1:0] find_rr(input logic [N-1:0] v, input logic [W-1:0] ptr);
      logic [W-1:0] r;
      logic         found;
      int           j;
      r     = {W{1'b0}};
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         j = (j >= N) ? (j - N) : j;
         r = (!found && v[W'(j)]) ? W'(j) : r;
         found = found || v[W'(j)];
      end
      return r;
   endfunction

   function automatic logic [W:0] pop_count(input logic [N-1:0] v);
      logic [W:0] c;
      c = {(W + 1){1'b0}};
      for (int i = 0; i < N; i++) begin
         c = c + {{W{1'b0}}, v[W'(i)]};
      end
      return c;
   endfunction

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_idx   = idx_q;
   assign out_none  = none_q;
   assign out_multi = multi_q;
   assign out_count = count_q;

   // Candidate result fields computed from the presented vector.
   always_comb begin
      accept_s  = in_valid && in_ready;
      idx_lsb_s = find_lsb(in_req);
      idx_msb_s = find_msb(in_req);
      idx_rr_s  = find_rr(in_req, rr_ptr_q);
      count_s   = pop_count(in_req);
      none_s    = (count_s == {(W + 1){1'b0}});
      multi_s   = (count_s >= (W + 1)'(2));
      case (mode)
         MODE_MSB: idx_sel_s = idx_msb_s;
         MODE_RR:  idx_sel_s = idx_rr_s;
         MODE_LSB: idx_sel_s = idx_lsb_s;
         default:  idx_sel_s = idx_lsb_s;
      endcase
   end

   // Next-state for the output stage and round-robin pointer; nothing moves without an accept.
   always_comb begin
      valid_d  = valid_q;
      idx_d    = idx_q;
      none_d   = none_q;
      multi_d  = multi_q;
      count_d  = count_q;
      rr_ptr_d = rr_ptr_q;
      if (accept_s) begin
         valid_d = 1'b1;
         idx_d   = idx_sel_s;
         none_d  = none_s;
         multi_d = multi_s;
         count_d = count_s;
         if (mode == MODE_RR && !none_s) begin
            rr_ptr_d = (idx_sel_s == W'(N - 1)) ? {W{1'b0}} : (idx_sel_s + W'(1));
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Output stage and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         idx_q    <= {W{1'b0}};
         none_q   <= 1'b0;
         multi_q  <= 1'b0;
         count_q  <= {(W + 1){1'b0}};
         rr_ptr_q <= {W{1'b0}};
      end else begin
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         none_q   <= none_d;
         multi_q  <= multi_d;
         count_q  <= count_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: doc/hex_prio_encoder_rr.md
Name: hex_prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's one-hot to binary encoder.
- Accepts an N-bit request vector over a valid/ready handshake and returns the index of the selected request one cycle later.
- Selection policy is runtime-selectable: LSB-first priority, MSB-first priority, or round-robin.
- Also reports a zero-vector flag, a multi-hot flag and a population count, so upstream decode logic can detect illegal non-one-hot inputs.

Parameters:
- N, 16, request vector width; any integer >= 2 (not required to be a power of two).
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector on in_req is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_req  input  N  request vector, bit i = request i.
- mode  input  2  sampled with in_req on accept: 0 = LSB-first, 1 = MSB-first, 2 = round-robin, 3 = reserved (treated as 0).
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream consumes the result.
- out_idx  output  W  selected request index.
- out_none  output  1  accepted vector was all zeros.
- out_multi  output  1  accepted vector had two or more bits set.
- out_count  output  W+1  number of set bits in the accepted vector.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_idx=0, out_none=0, out_multi=0, out_count=0, round-robin pointer rr_ptr=0. in_ready is combinational and therefore reads 1 during reset.
- in_ready = !out_valid || out_ready. This gives a single output stage with pass-through backpressure and full throughput of one vector per cycle.
- Accept: in_valid && in_ready at a rising edge. All result fields are computed from in_req and mode and registered at that edge, so latency is exactly 1 cycle from accept to out_valid=1.
- Consume: out_valid && out_ready. If there is no simultaneous accept, out_valid clears next edge. Data fields hold their last values after out_valid clears.
- Simultaneous consume and accept in one cycle: out_valid stays 1 and the fields update to the new vector; no bubble.
- Result fields are stable while out_valid=1 && out_ready=0.
- Index selection:
  - mode 0: lowest set bit.
  - mode 1: highest set bit.
  - mode 2: first set bit at or above rr_ptr, searching upward and wrapping from N-1 to 0.
- rr_ptr update: only on an accept in mode 2 with a non-zero vector, rr_ptr <= (out_idx_next == N-1) ? 0 : out_idx_next + 1. Modes 0 and 1 and zero vectors leave rr_ptr unchanged.
- Zero vector: out_idx=0, out_none=1, out_multi=0, out_count=0. out_valid is still asserted; zero vectors are not dropped.
- out_multi = (out_count >= 2). A one-hot input gives out_none=0, out_multi=0, out_count=1, and out_idx equals the legacy encoder output for every mode.
- in_req and mode are don't-care when no accept occurs. X on them must not propagate into the registers without an accept.
- Reset asserted mid-transfer: a pending result is discarded and rr_ptr returns to 0. The first accept after deassertion behaves as after power-up.
- The index search is purely combinational feeding the registers. No multi-cycle search is permitted, at any N.

Test Plan:
- Reset and one-hot sweep: N=16, mode 0, out_ready=1, drive in_req=1<<i for i=0..15 back-to-back. Expect out_idx=i one cycle after each accept, out_count=1, out_none=0, out_multi=0, in_ready constantly 1.
- Priority modes: in_req=16'h8421 in mode 0 gives out_idx=0. The same vector in mode 1 gives out_idx=15. Both give out_count=4 and out_multi=1. mode 3 gives out_idx=0.
- Round-robin fairness: mode 2, hold in_req=16'h0101 for 4 accepts. Expect out_idx sequence 0, 8, 0, 8 and rr_ptr sequence 1, 9, 1, 9. Then send 16'h8000 followed by 16'h0001 and expect idx 15 then 0, with the pointer wrapping to 0 after idx 15.
- Backpressure: out_ready=0 after first accept of 16'h0010. Expect in_ready=0 and out_idx=4 held for 5 cycles with in_req changing to 16'h0200 underneath. Raise out_ready together with in_valid: expect same-cycle accept, out_idx=9 next cycle, out_valid never drops.
- Zero vector: accept in_req=0 in mode 2 with rr_ptr=5. Expect out_none=1, out_idx=0, out_count=0, out_valid=1, rr_ptr still 5.
- Async reset mid-operation: with out_valid=1, out_ready=0 and rr_ptr=7, pulse rst_n low between clock edges. Expect out_valid=0 immediately. Then accept 16'h0081 in mode 2 and expect out_idx=0.
- Parameter check: N=5 (W=3), mode 2, rr_ptr=4, in_req=5'b00110. Expect out_idx=1 (wrapped search), out_count=2.
